// File: rtl/drp_responder.sv
// DRP slave: read/write register bank, read-only status words and a saturating
// protocol-error counter, all answered with a fixed response latency.
module drp_responder #(
  parameter int DRP_DATA_WIDTH = 16,
  parameter int DRP_ADDR_WIDTH = 7,
  parameter int REG_COUNT      = 8,
  parameter int LATENCY        = 2,
  parameter     DEBUG          = "false"
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                drp_en,
  input  logic                                drp_we,
  input  logic [DRP_ADDR_WIDTH-1:0]           drp_addr,
  input  logic [DRP_DATA_WIDTH-1:0]           drp_di,
  output logic                                drp_rdy,
  output logic [DRP_DATA_WIDTH-1:0]           drp_do,
  output logic [REG_COUNT*DRP_DATA_WIDTH-1:0] regOut,
  input  logic [REG_COUNT*DRP_DATA_WIDTH-1:0] statusIn,
  output logic                                protocolError
);

  // state | meaning
  // IDLE  | no transaction; drp_en is accepted
  // BUSY  | transaction in flight, up to and including the drp_rdy cycle
  typedef enum logic {IDLE, BUSY} state_t;

  (* mark_debug = DEBUG *) state_t state;

  logic [3:0]                          cnt;
  logic                                lat_we;
  logic [DRP_ADDR_WIDTH-1:0]           lat_addr;
  logic [DRP_DATA_WIDTH-1:0]           lat_di;
  logic [7:0]                          err_cnt;
  logic [REG_COUNT*DRP_DATA_WIDTH-1:0] reg_q;

  logic                                fire;
  logic                                f_we;
  logic [DRP_ADDR_WIDTH-1:0]           f_addr;
  logic [DRP_DATA_WIDTH-1:0]           f_di;
  logic [DRP_DATA_WIDTH-1:0]           rd_val;
  logic                                err_det;
  logic                                clr;
  int                                  a;

  // With LATENCY=1 the access completes on the accepting edge, so it uses the
  // live request inputs instead of the latched copies.
  always_comb begin
    err_det = drp_en && (state == BUSY);
    if (state == IDLE) begin
      fire   = drp_en && (LATENCY == 1);
      f_we   = drp_we;
      f_addr = drp_addr;
      f_di   = drp_di;
    end else begin
      fire   = !drp_rdy && (cnt == 4'd1);
      f_we   = lat_we;
      f_addr = lat_addr;
      f_di   = lat_di;
    end
    a      = 32'(f_addr);
    rd_val = '0;
    for (int k = 0; k < REG_COUNT; k++) begin
      if (a == k)             rd_val = reg_q[k*DRP_DATA_WIDTH +: DRP_DATA_WIDTH];
      if (a == REG_COUNT + k) rd_val = statusIn[k*DRP_DATA_WIDTH +: DRP_DATA_WIDTH];
    end
    if (a == 2*REG_COUNT) rd_val = DRP_DATA_WIDTH'(err_cnt);
    clr = fire && f_we && (a == 2*REG_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_di        <= '0;
      drp_rdy       <= 1'b0;
      drp_do        <= '0;
      protocolError <= 1'b0;
      err_cnt       <= '0;
      reg_q         <= '0;
    end else begin
      drp_rdy       <= fire;
      drp_do        <= (fire && !f_we) ? rd_val : '0;
      protocolError <= err_det;

      case (state)
        IDLE: begin
          if (drp_en) begin
            state    <= BUSY;
            cnt      <= 4'(LATENCY - 1);
            lat_we   <= drp_we;
            lat_addr <= drp_addr;
            lat_di   <= drp_di;
          end
        end
        BUSY: begin
          if (drp_rdy)    state <= IDLE;
          else if (!fire) cnt   <= cnt - 4'd1;
        end
      endcase

      if (fire && f_we) begin
        for (int k = 0; k < REG_COUNT; k++) begin
          if (a == k) reg_q[k*DRP_DATA_WIDTH +: DRP_DATA_WIDTH] <= f_di;
        end
      end

      // A clear landing together with a rejected request leaves that one error counted.
      if (clr)                                err_cnt <= err_det ? 8'd1 : 8'd0;
      else if (err_det && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
    end
  end

  assign regOut = reg_q;

endmodule

// File: tb/tb_drp_responder.sv
// Randomized bench for drp_responder: LATENCY=2 and LATENCY=1 instances share
// one stimulus stream and are checked against a cycle-indexed transaction model.
module tb_drp_responder;

  localparam int W     = 16;
  localparam int AW    = 7;
  localparam int RC    = 8;
  localparam int ERR_A = 2*RC;

  int lat [2] = '{2, 1};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          drp_en = 1'b0;
  logic          drp_we = 1'b0;
  logic [AW-1:0] drp_addr = '0;
  logic [W-1:0]  drp_di = '0;
  logic [RC*W-1:0] status_in = '0;

  logic            rdy     [2];
  logic [W-1:0]    dout    [2];
  logic            perr    [2];
  logic [RC*W-1:0] reg_out [2];

  drp_responder #(.DRP_DATA_WIDTH(W), .DRP_ADDR_WIDTH(AW), .REG_COUNT(RC),
                  .LATENCY(2), .DEBUG("false")) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .drp_en(drp_en), .drp_we(drp_we),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_rdy(rdy[0]), .drp_do(dout[0]),
    .regOut(reg_out[0]), .statusIn(status_in), .protocolError(perr[0]));

  drp_responder #(.DRP_DATA_WIDTH(W), .DRP_ADDR_WIDTH(AW), .REG_COUNT(RC),
                  .LATENCY(1), .DEBUG("false")) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .drp_en(drp_en), .drp_we(drp_we),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_rdy(rdy[1]), .drp_do(dout[1]),
    .regOut(reg_out[1]), .statusIn(status_in), .protocolError(perr[1]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a pending transaction accepted in cycle m_acc completes with
  // drp_rdy high in cycle m_acc+lat; the unit is busy in cycles m_acc+1..m_acc+lat.
  bit           m_pend [2];
  int           m_acc  [2];
  bit           m_we   [2];
  int           m_addr [2];
  logic [W-1:0] m_di   [2];
  logic [W-1:0] m_reg  [2][RC];
  int           m_err  [2];
  bit           e_rdy  [2];
  logic [W-1:0] e_do   [2];
  bit           e_perr [2];
  logic [W-1:0] rd_cap [2];

  task automatic chk(input string tag, input logic [RC*W-1:0] got, input logic [RC*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_read(input int i, input int addr);
    if (addr < RC)     return m_reg[i][addr];
    if (addr < 2*RC)   return status_in[(addr-RC)*W +: W];
    if (addr == ERR_A) return W'(m_err[i]);
    return '0;
  endfunction

  function automatic logic [RC*W-1:0] packed_regs(input int i);
    logic [RC*W-1:0] p;
    for (int k = 0; k < RC; k++) p[k*W +: W] = m_reg[i][k];
    return p;
  endfunction

  task automatic reset_models();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0;
      m_err[i]  = 0;
      e_rdy[i]  = 1'b0;
      e_do[i]   = '0;
      e_perr[i] = 1'b0;
      for (int k = 0; k < RC; k++) m_reg[i][k] = '0;
    end
  endtask

  // Called just after a falling edge: checks this cycle's outputs, drives the
  // next inputs and advances the model across the coming rising edge.
  task automatic step(input bit en, input bit we, input int addr, input logic [W-1:0] di);
    bit busy;
    bit err;
    bit clr;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rdy_l%0d", lat[i]),  rdy[i],     e_rdy[i]);
      chk($sformatf("do_l%0d", lat[i]),   dout[i],    e_do[i]);
      chk($sformatf("perr_l%0d", lat[i]), perr[i],    e_perr[i]);
      chk($sformatf("regs_l%0d", lat[i]), reg_out[i], packed_regs(i));
      if (rdy[i]) rd_cap[i] = dout[i];
    end
    drp_en   = en;
    drp_we   = we;
    drp_addr = AW'(addr);
    drp_di   = di;
    for (int i = 0; i < 2; i++) begin
      busy = m_pend[i] && (cyc <= m_acc[i] + lat[i]);
      if (busy && cyc == m_acc[i] + lat[i]) m_pend[i] = 1'b0;
      err       = en && busy;
      clr       = 1'b0;
      e_rdy[i]  = 1'b0;
      e_do[i]   = '0;
      if (en && !busy) begin
        m_pend[i] = 1'b1;
        m_acc[i]  = cyc;
        m_we[i]   = we;
        m_addr[i] = addr;
        m_di[i]   = di;
      end
      if (m_pend[i] && cyc + 1 == m_acc[i] + lat[i]) begin
        e_rdy[i] = 1'b1;
        if (!m_we[i])            e_do[i] = model_read(i, m_addr[i]);
        else if (m_addr[i] < RC) m_reg[i][m_addr[i]] = m_di[i];
        else if (m_addr[i] == ERR_A) clr = 1'b1;
      end
      if (clr)                      m_err[i] = err ? 1 : 0;
      else if (err && m_err[i] < 255) m_err[i]++;
      e_perr[i] = err;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 127), W'($urandom));
  endtask

  task automatic do_reset(input int hold);
    rst_n  = 1'b0;
    drp_en = 1'b0;
    drp_we = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdy",  rdy[i],     '0);
      chk("rst_do",   dout[i],    '0);
      chk("rst_perr", perr[i],    '0);
      chk("rst_regs", reg_out[i], '0);
    end
    reset_models();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_back(input int addr, input logic [W-1:0] exp, input string tag);
    rd_cap[0] = 16'hDEAD;
    rd_cap[1] = 16'hDEAD;
    step(1'b1, 1'b0, addr, '0);
    idle(3);
    chk({tag, "_l2"}, rd_cap[0], exp);
    chk({tag, "_l1"}, rd_cap[1], exp);
  endtask

  initial begin
    reset_models();
    @(negedge clk);
    do_reset(2);

    step(1'b1, 1'b1, 3, 16'hA5A5);
    idle(4);
    chk("wr3_regout", reg_out[0][3*W +: W], 16'hA5A5);

    for (int k = 0; k < RC; k++) status_in[k*W +: W] = W'($urandom);
    status_in[1*W +: W] = 16'h1234;
    read_back(3, 16'hA5A5, "rd3");
    read_back(RC + 1, 16'h1234, "rd_status1");
    read_back(7'h7F, 16'h0000, "rd_unmapped");

    step(1'b1, 1'b0, 0, '0);
    step(1'b1, 1'b0, 0, '0);
    idle(3);
    read_back(ERR_A, 16'd1, "err_one");

    step(1'b1, 1'b1, ERR_A, '0);
    idle(3);
    repeat (700) step(1'b1, 1'b0, 0, '0);
    idle(3);
    read_back(ERR_A, 16'd255, "err_sat");
    step(1'b1, 1'b1, ERR_A, '0);
    idle(3);
    read_back(ERR_A, 16'd0, "err_clear");

    step(1'b1, 1'b1, ERR_A, '0);
    step(1'b1, 1'b0, 0, '0);
    idle(3);
    read_back(ERR_A, 16'd1, "err_clr_collide");

    step(1'b1, 1'b1, 5, 16'hBEEF);
    do_reset(1);
    idle(4);
    chk("rst_inflight_reg5", reg_out[0][5*W +: W], 16'h0000);

    step(1'b1, 1'b1, 4, 16'h5A5A);
    step(1'b0, 1'b0, 0, '0);
    rd_cap[1] = 16'hDEAD;
    step(1'b1, 1'b0, 4, '0);
    idle(3);
    chk("b2b_rd_l1", rd_cap[1], 16'h5A5A);

    repeat (3000) begin
      for (int k = 0; k < RC; k++) status_in[k*W +: W] = W'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      step(($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 127 : $urandom_range(0, 2*RC + 2),
           W'($urandom));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
